// File: rtl/vel_ramp_sequencer.sv
// vel_ramp_sequencer: paces bounded signed velocity steps toward a commanded
// speed once per prescaler tick, holds at target, re-ramps when the speed drifts
// by more than HYST, and latches an overflow fault until cleared.
// Optional feature: define RAMP_WATCHDOG_EN to build the ramp step watchdog
// (fault_code 10 after WDOG_STEPS steps without reaching target).
module vel_ramp_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int STEP_MAX   = 8,
  parameter int VEL_MAX    = 254,
  parameter int HYST       = 2,
  parameter int WDOG_STEPS = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] target_vel,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [7:0] cur_vel,
  input  logic       ovf,
  input  logic       fault_clr,
  output logic [8:0] step_out,
  output logic       step_valid,
  output logic       at_target,
  output logic       busy,
  output logic [1:0] fault_code
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
  localparam logic [PW-1:0]     PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [7:0]        VEL_CAP   = 8'(VEL_MAX);
  localparam logic signed [8:0] STEP_HI   = 9'(STEP_MAX);
  localparam logic signed [8:0] STEP_LO   = 9'(-STEP_MAX);
  localparam logic [8:0]        HYST_U    = 9'(HYST);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD, S_FAULT} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PW-1:0]       r_presc;
  logic [PW-1:0]       w_presc_next;
  logic [7:0]          r_tgt;
  logic [7:0]          w_tgt_next;
  logic [8:0]          r_step;
  logic [8:0]          w_step_next;
  logic                r_valid;
  logic                w_valid_next;
  logic [1:0]          r_fault_code;
  logic [1:0]          w_code_next;

  logic                w_live;
  logic                w_tick;
  logic                w_load;
  logic                w_wdog_trip;
  logic [7:0]          w_tgt_clamped;
  logic signed [8:0]   w_err;
  logic signed [8:0]   w_step;
  logic [8:0]          w_abs_err;

  assign w_live        = (r_state == S_RAMP) || (r_state == S_HOLD);
  assign w_tick        = w_live && (r_presc == '0);
  assign w_load        = target_valid && target_ready;
  assign w_tgt_clamped = (target_vel > VEL_CAP) ? VEL_CAP : target_vel;
  // Both operands are zero-extended so the difference spans -255..+255 in 9 bits.
  assign w_err         = $signed({1'b0, r_tgt}) - $signed({1'b0, cur_vel});
  assign w_step        = (w_err > STEP_HI) ? STEP_HI : ((w_err < STEP_LO) ? STEP_LO : w_err);
  assign w_abs_err     = w_err[8] ? 9'(-w_err) : 9'(w_err);

  assign target_ready  = (r_state != S_FAULT);
  assign at_target     = (r_state == S_HOLD);
  assign busy          = (r_state == S_RAMP);
  assign step_out      = r_step;
  assign step_valid    = r_valid;
  assign fault_code    = r_fault_code;

`ifdef RAMP_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_STEPS + 1);
  logic [CW-1:0] r_wdog_cnt;
  logic          w_wdog_clr;

  // Entry into RAMP from another state, or a fresh load while ramping, restarts the count.
  assign w_wdog_clr  = (w_state_next == S_RAMP) && ((r_state != S_RAMP) || w_load);
  assign w_wdog_trip = (r_state == S_RAMP) && (r_wdog_cnt >= CW'(WDOG_STEPS));

  // Count steps issued since the ramp (re)started.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wdog_cnt <= '0;
    end else if (w_wdog_clr) begin
      r_wdog_cnt <= '0;
    end else if (w_valid_next) begin
      r_wdog_cnt <= r_wdog_cnt + CW'(1);
    end
  end
`else
  assign w_wdog_trip = 1'b0;
`endif

  // Next state and next registered outputs; overflow outranks every other event.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_tgt_next   = r_tgt;
    w_step_next  = '0;
    w_valid_next = 1'b0;
    w_code_next  = r_fault_code;
    if (w_live) begin
      w_presc_next = (r_presc == '0) ? PRESC_TOP : r_presc - PW'(1);
    end
    if (w_live && ovf) begin
      w_state_next = S_FAULT;
      w_code_next  = 2'b01;
    end else if (r_state == S_FAULT) begin
      // A still-asserted overflow keeps us latched even with fault_clr high.
      if (fault_clr && !ovf) begin
        w_state_next = S_IDLE;
        w_code_next  = 2'b00;
        w_tgt_next   = '0;
      end
    end else if (w_wdog_trip) begin
      w_state_next = S_FAULT;
      w_code_next  = 2'b10;
    end else if (w_load) begin
      w_state_next = S_RAMP;
      w_tgt_next   = w_tgt_clamped;
      w_presc_next = PRESC_TOP;
    end else if (w_tick) begin
      if (r_state == S_RAMP) begin
        if (w_err == '0) begin
          w_state_next = S_HOLD;
        end else begin
          w_step_next  = w_step;
          w_valid_next = 1'b1;
        end
      end else if (w_abs_err > HYST_U) begin
        // Re-ramp only; the first corrective step waits for the next tick.
        w_state_next = S_RAMP;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_presc      <= PRESC_TOP;
      r_tgt        <= '0;
      r_step       <= '0;
      r_valid      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_tgt        <= w_tgt_next;
      r_step       <= w_step_next;
      r_valid      <= w_valid_next;
      r_fault_code <= w_code_next;
    end
  end

endmodule

// File: tb/tb_vel_ramp_sequencer.sv
// Bench for vel_ramp_sequencer: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a timestamp-based reference model.
module tb_vel_ramp_sequencer;

  localparam int TD = 4;
  localparam int SM = 8;
  localparam int VM = 254;
  localparam int HY = 2;
  localparam int WD = 64;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] target_vel;
  logic       target_valid;
  logic       target_ready;
  logic [7:0] cur_vel;
  logic       ovf;
  logic       fault_clr;
  logic [8:0] step_out;
  logic       step_valid;
  logic       at_target;
  logic       busy;
  logic [1:0] fault_code;

  vel_ramp_sequencer #(
    .TICK_DIV  (TD),
    .STEP_MAX  (SM),
    .VEL_MAX   (VM),
    .HYST      (HY),
    .WDOG_STEPS(WD)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .target_vel  (target_vel),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .cur_vel     (cur_vel),
    .ovf         (ovf),
    .fault_clr   (fault_clr),
    .step_out    (step_out),
    .step_valid  (step_valid),
    .at_target   (at_target),
    .busy        (busy),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model state: mode, latched target, fault code, cycle of last load,
  // steps since the ramp started, and the step expected after the current edge.
  int m_mode     = M_IDLE;
  int m_tgt      = 0;
  int m_code     = 0;
  int m_load_cyc = 0;
  int m_nsteps   = 0;
  int exp_step   = 0;

  int acc   = 0;
  bit track = 1'b1;
  int obs_q[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    bit live;
    bit tick;
    int err;
    int mag;
    cyc++;
    exp_step = 0;
    live = (m_mode == M_RAMP) || (m_mode == M_HOLD);
    tick = live && (cyc > m_load_cyc) && (((cyc - m_load_cyc) % TD) == 0);
    if (!rst_n) begin
      m_mode = M_IDLE; m_tgt = 0; m_code = 0; m_nsteps = 0;
    end else if (live && ovf) begin
      m_mode = M_FAULT; m_code = 1;
    end else if (m_mode == M_FAULT) begin
      if (fault_clr && !ovf) begin
        m_mode = M_IDLE; m_code = 0; m_tgt = 0;
      end
`ifdef RAMP_WATCHDOG_EN
    end else if (m_mode == M_RAMP && m_nsteps >= WD) begin
      m_mode = M_FAULT; m_code = 2;
`endif
    end else if (target_valid) begin
      m_tgt = (int'(target_vel) > VM) ? VM : int'(target_vel);
      m_mode = M_RAMP; m_load_cyc = cyc; m_nsteps = 0;
      $display("load cyc=%0d req=%0d tgt=%0d speed=%0d", cyc, target_vel, m_tgt, cur_vel);
    end else if (tick) begin
      err = m_tgt - int'(cur_vel);
      mag = (err < 0) ? -err : err;
      if (m_mode == M_RAMP) begin
        if (err == 0) m_mode = M_HOLD;
        else begin
          exp_step = (err > SM) ? SM : ((err < -SM) ? -SM : err);
          m_nsteps++;
        end
      end else if (mag > HY) begin
        m_mode = M_RAMP; m_nsteps = 0;
      end
    end
  endtask

  // Advance one clock, compare every output with the model, then integrate the
  // step that was on step_out before this edge into the accumulator stand-in.
  task automatic run_cycle();
    int prev;
    prev = exp_step;
    @(posedge clk);
    model_edge();
    #1;
    check_val("step_out",   int'($signed(step_out)), exp_step);
    check_val("step_valid", int'(step_valid), (exp_step != 0) ? 1 : 0);
    check_val("at_target",  int'(at_target),  (m_mode == M_HOLD) ? 1 : 0);
    check_val("busy",       int'(busy),       (m_mode == M_RAMP) ? 1 : 0);
    check_val("fault_code", int'(fault_code), m_code);
    check_val("ready",      int'(target_ready), (m_mode != M_FAULT) ? 1 : 0);
    if (step_valid) obs_q.push_back(int'($signed(step_out)));
    acc = acc + prev;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    if (track) cur_vel = 8'(acc);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_load(input int v);
    target_vel   = 8'(v);
    target_valid = 1'b1;
    run_cycle();
    target_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; target_vel = '0; target_valid = 1'b0; cur_vel = '0;
    ovf = 1'b0; fault_clr = 1'b0;

    // Reset held two cycles.
    run_n(2);
    check_val("rst_step",  int'(step_out), 0);
    check_val("rst_valid", int'(step_valid), 0);
    check_val("rst_ready", int'(target_ready), 1);
    check_val("rst_busy",  int'(busy), 0);
    check_val("rst_code",  int'(fault_code), 0);
    rst_n = 1'b1;
    acc = 0; cur_vel = '0;

    // Ramp up 0 -> 20.
    obs_q.delete();
    do_load(20);
    run_n(16);
    check_val("t2_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check_val("t2_s0", obs_q[0], 8);
      check_val("t2_s1", obs_q[1], 8);
      check_val("t2_s2", obs_q[2], 4);
    end
    check_val("t2_hold", int'(at_target), 1);

    // Ramp down 20 -> 5, then disturb in HOLD.
    obs_q.delete();
    do_load(5);
    run_n(16);
    check_val("t3_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check_val("t3_s0", obs_q[0], -8);
      check_val("t3_s1", obs_q[1], -7);
    end
    check_val("t3_hold", int'(at_target), 1);
    track = 1'b0; cur_vel = 8'd8;
    obs_q.delete();
    run_n(12);
    check_val("t3_rearm", (obs_q.size() > 0) ? obs_q[0] : 0, -3);
    check_val("t3_busy", int'(busy), 1);

    // Clamp of an over-range target.
    pulse_reset();
    acc = 250; cur_vel = 8'd250; track = 1'b1;
    obs_q.delete();
    do_load(255);
    run_n(16);
    check_val("t4_count", obs_q.size(), 1);
    check_val("t4_s0", (obs_q.size() > 0) ? obs_q[0] : 0, 4);
    check_val("t4_hold", int'(at_target), 1);
    check_val("t4_speed", int'(cur_vel), 254);

    // Overflow mid-ramp, ignored load, sticky with ovf, then clear.
    do_load(100);
    run_n(6);
    ovf = 1'b1; run_cycle(); ovf = 1'b0;
    check_val("t5_code", int'(fault_code), 1);
    check_val("t5_step", int'(step_out), 0);
    check_val("t5_ready", int'(target_ready), 0);
    do_load(30);
    check_val("t5_noload", int'(busy), 0);
    ovf = 1'b1; fault_clr = 1'b1; run_cycle(); ovf = 1'b0;
    check_val("t5_sticky", int'(fault_code), 1);
    run_cycle(); fault_clr = 1'b0;
    check_val("t5_clr_code", int'(fault_code), 0);
    check_val("t5_clr_ready", int'(target_ready), 1);

    // Speed pinned at 0: watchdog fault, or endless steps without it.
    pulse_reset();
    track = 1'b0; cur_vel = '0;
    obs_q.delete();
    do_load(100);
    run_n(TD * WD + 8);
`ifdef RAMP_WATCHDOG_EN
    check_val("t6_count", obs_q.size(), WD);
    check_val("t6_code", int'(fault_code), 2);
`else
    check_val("t6_count", obs_q.size(), (TD * WD + 8) / TD);
    check_val("t6_code", int'(fault_code), 0);
`endif
    check_val("t6_first", (obs_q.size() > 0) ? obs_q[0] : 0, 8);
    fault_clr = 1'b1; run_cycle(); fault_clr = 1'b0;

    // Randomized traffic with the speed tracking the accumulator.
    pulse_reset();
    acc = 0; cur_vel = '0; track = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 599) != 0);
      ovf          = ($urandom_range(0, 149) == 0);
      fault_clr    = ($urandom_range(0, 7) == 0);
      target_valid = ($urandom_range(0, 24) == 0);
      target_vel   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 59) == 0) begin
        acc = $urandom_range(0, 255);
        cur_vel = 8'(acc);
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
